// File: rtl/kmap_vector_sequencer.sv
// Exhaustive 16-vector stimulus sequencer for the 4-input K-map block; captures k_out per vector.
// Optional golden-table comparator and pass flag are enabled by defining KMAP_SEQ_COMPARE_EN.
module kmap_vector_sequencer #(
    parameter int unsigned DWELL    = 100,
    parameter logic [15:0] EXPECTED = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        k_out_in,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic [3:0]  vec_idx,
    output logic        busy,
    output logic        done,
    output logic [15:0] truth_table
`ifdef KMAP_SEQ_COMPARE_EN
    ,
    output logic        pass
`endif
);

    // state | meaning
    // IDLE  | waiting for start; truth_table holds last result
    // DRIVE | presenting vec_idx on a..d, counting dwell, sampling k_out_in at dwell end
    // DONE  | single-cycle completion pulse, vector held at 1111
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [15:0] CNT_LAST = 16'(DWELL - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  vec_q, vec_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] tt_q, tt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        tt_d    = tt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    state_d = S_DRIVE;
                    vec_d   = 4'd0;
                    cnt_d   = 16'd0;
                    tt_d    = 16'h0000;
                    busy_d  = 1'b1;
                    pass_d  = 1'b0;
                end
            end
            S_DRIVE: begin
                if (cnt_q == CNT_LAST) begin
                    tt_d[vec_q] = k_out_in;
                    if (vec_q != 4'd15) begin
                        vec_d = vec_q + 4'd1;
                        cnt_d = 16'd0;
                    end else begin
                        // counter stays saturated at DWELL-1 until the next launch
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (tt_d == EXPECTED);
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            vec_q   <= 4'd0;
            cnt_q   <= 16'd0;
            tt_q    <= 16'h0000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            tt_q    <= tt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (DWELL < 2) begin
            $error("kmap_vector_sequencer: DWELL=%0d is below the minimum of 2", DWELL);
        end
`ifdef KMAP_SEQ_COMPARE_EN
        if (!rst && state_q == S_DRIVE && cnt_q == CNT_LAST && vec_q == 4'd15) begin
            for (int i = 0; i < 16; i++) begin
                if (tt_d[i] != EXPECTED[i]) begin
                    $display("kmap_vector_sequencer: mismatch at vector %0d: got %b expected %b",
                             i, tt_d[i], EXPECTED[i]);
                end
            end
        end
`endif
    end
`endif

    assign a           = vec_q[3];
    assign b           = vec_q[2];
    assign c           = vec_q[1];
    assign d           = vec_q[0];
    assign vec_idx     = vec_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign truth_table = tt_q;
`ifdef KMAP_SEQ_COMPARE_EN
    assign pass        = pass_q;
`else
    logic unused_pass;
    assign unused_pass = pass_q;
`endif

endmodule
